// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink
// Receiving end of the pixel plot interface. Single-cycle plot requests are
// queued in a small FIFO and then written into a 160x120x3 single-port
// framebuffer. Display reads share the memory port and always win. A clear
// engine fills the whole screen with one colour. Plots that arrive during a
// clear are queued, and they drain after the clear so they land on top of it.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   plotEn        pixel write request (no backpressure)
//   x, y          pixel column (0..159) and row (0..119)
//   colour        pixel colour
//   clear_start   start a full-screen clear (ignored while clearing)
//   clear_colour  fill colour, captured when the clear starts
//   rd_req        display read request (highest priority)
//   rd_addr       display read address
//   fb_addr       framebuffer address     (combinational)
//   fb_data       framebuffer write data  (combinational)
//   fb_wren       framebuffer write enable (combinational)
//   fifo_full     FIFO holds DEPTH entries (registered)
//   busy          FIFO non-empty or clearing (registered)
//   clear_done    one-cycle pulse after the last clear write (registered)
//   dropped       saturating count of discarded plots (registered)
module pixel_plot_sink #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        plotEn,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic        clear_start,
  input  logic [2:0]  clear_colour,
  input  logic        rd_req,
  input  logic [14:0] rd_addr,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_wren,
  output logic        fifo_full,
  output logic        busy,
  output logic        clear_done,
  output logic [7:0]  dropped
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [14:0]  LAST_ADDR = 15'd19199;

  typedef enum logic {
    ST_DRAIN = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [17:0]   fifo_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [14:0]   clr_cnt_q, clr_cnt_d;
  logic [2:0]    clr_col_q, clr_col_d;
  logic          fifo_full_q, busy_q, clear_done_q, clear_done_d;
  logic [7:0]    dropped_q, dropped_d;

  logic [14:0]   plot_addr_s;
  logic          in_range_s, fifo_empty_s, fifo_full_s;
  logic          push_s, pop_s, drop_s;
  logic [17:0]   head_s;

  // y*160 + x, formed as (y<<7) + (y<<5) + x so no multiplier is needed
  assign plot_addr_s  = {1'b0, y, 7'd0} + {3'd0, y, 5'd0} + {7'd0, x};
  assign in_range_s   = (x < 8'd160) && (y < 7'd120);
  assign fifo_empty_s = (count_q == '0);
  assign fifo_full_s  = (count_q == DEPTH_CNT);
  assign head_s       = fifo_mem_q[rd_ptr_q];

  // A full FIFO still accepts a plot when the head pops on the same edge
  assign push_s = plotEn && in_range_s && (!fifo_full_s || pop_s);
  assign drop_s = plotEn && !push_s;

  // Next state, framebuffer port mux and clear counter
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clr_col_d    = clr_col_q;
    clear_done_d = 1'b0;
    pop_s        = 1'b0;
    fb_addr      = 15'd0;
    fb_data      = 3'd0;
    fb_wren      = 1'b0;
    case (state_q)
      ST_DRAIN: begin
        if (rd_req) begin
          fb_addr = rd_addr;
        end else if (!fifo_empty_s) begin
          fb_addr = head_s[17:3];
          fb_data = head_s[2:0];
          fb_wren = 1'b1;
          pop_s   = 1'b1;
        end else begin
          fb_wren = 1'b0;
        end
        if (clear_start) begin
          state_d   = ST_CLEAR;
          clr_col_d = clear_colour;
          clr_cnt_d = 15'd0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        if (rd_req) begin
          // Reads stall the sweep; the counter holds
          fb_addr = rd_addr;
        end else begin
          fb_addr = clr_cnt_q;
          fb_data = clr_col_q;
          fb_wren = 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            state_d      = ST_DRAIN;
            clear_done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + 15'd1;
          end
        end
      end
      default: begin
        state_d = ST_DRAIN;
      end
    endcase
  end

  // FIFO occupancy and saturating drop counter
  always_comb begin
    count_d = count_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
    if (drop_s && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end else begin
      dropped_d = dropped_q;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= {plot_addr_s, colour};
    end
  end

  // Control state, pointers and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_DRAIN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      clr_cnt_q    <= 15'd0;
      clr_col_q    <= 3'd0;
      fifo_full_q  <= 1'b0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
      dropped_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q      <= count_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_col_q    <= clr_col_d;
      fifo_full_q  <= (count_d == DEPTH_CNT);
      busy_q       <= (count_d != '0) || (state_d == ST_CLEAR);
      clear_done_q <= clear_done_d;
      dropped_q    <= dropped_d;
    end
  end

  assign fifo_full  = fifo_full_q;
  assign busy       = busy_q;
  assign clear_done = clear_done_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_pixel_plot_sink.sv
module tb_pixel_plot_sink;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        plotEn;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        clear_start;
  logic [2:0]  clear_colour;
  logic        rd_req;
  logic [14:0] rd_addr;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_wren;
  logic        fifo_full;
  logic        busy;
  logic        clear_done;
  logic [7:0]  dropped;

  pixel_plot_sink #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .plotEn(plotEn), .x(x), .y(y), .colour(colour),
    .clear_start(clear_start), .clear_colour(clear_colour),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_wren(fb_wren),
    .fifo_full(fifo_full), .busy(busy), .clear_done(clear_done),
    .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic obs_wren;

  // Reference model: queue of pending pixels (addr*8 + colour), drop count,
  // and the clear sweep described as "clearing / next address / colour".
  int m_q[$];
  int m_drop;
  bit m_clearing;
  int m_cnt;
  int m_ccol;
  bit m_done;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drop     = 0;
    m_clearing = 1'b0;
    m_cnt      = 0;
    m_ccol     = 0;
    m_done     = 1'b0;
  endtask

  task automatic set_idle();
    plotEn       = 1'b0;
    x            = 8'd0;
    y            = 7'd0;
    colour       = 3'd0;
    clear_start  = 1'b0;
    clear_colour = 3'd0;
    rd_req       = 1'b0;
    rd_addr      = 15'd0;
  endtask

  // One clock cycle with the inputs already applied: check the port mux
  // mid-cycle, advance the model, then check the registered outputs.
  task automatic cycle();
    int  e_addr, e_data, pix;
    bit  e_wren, pop, push;
    @(negedge clk);
    if (rd_req) begin
      e_addr = int'(rd_addr); e_data = 0; e_wren = 1'b0;
    end else if (m_clearing) begin
      e_addr = m_cnt; e_data = m_ccol; e_wren = 1'b1;
    end else if (m_q.size() > 0) begin
      e_addr = m_q[0] / 8; e_data = m_q[0] % 8; e_wren = 1'b1;
    end else begin
      e_addr = 0; e_data = 0; e_wren = 1'b0;
    end
    check_val("fb_wren", 32'(fb_wren), 32'(e_wren));
    check_val("fb_addr", 32'(fb_addr), 32'(e_addr));
    if (!rd_req) check_val("fb_data", 32'(fb_data), 32'(e_data));
    obs_wren = fb_wren;

    pop  = !m_clearing && !rd_req && (m_q.size() > 0);
    push = 1'b0;
    pix  = (int'(y) * 160 + int'(x)) * 8 + int'(colour);
    if (plotEn) begin
      if (int'(x) > 159 || int'(y) > 119 || (m_q.size() == DEPTH && !pop)) begin
        if (m_drop < 255) m_drop++;
      end else begin
        push = 1'b1;
      end
    end
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(pix);

    m_done = 1'b0;
    if (m_clearing) begin
      if (!rd_req) begin
        if (m_cnt == 19199) begin
          m_clearing = 1'b0;
          m_done     = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end else if (clear_start) begin
      m_clearing = 1'b1;
      m_cnt      = 0;
      m_ccol     = int'(clear_colour);
    end

    @(posedge clk);
    #1;
    check_val("dropped",    32'(dropped),    32'(m_drop));
    check_val("fifo_full",  32'(fifo_full),  32'(m_q.size() == DEPTH));
    check_val("busy",       32'(busy),       32'((m_q.size() != 0) || m_clearing));
    check_val("clear_done", 32'(clear_done), 32'(m_done));
  endtask

  task automatic plot(input int px, input int py, input int pc);
    plotEn = 1'b1;
    x      = 8'(px);
    y      = 7'(py);
    colour = 3'(pc);
    cycle();
    plotEn = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_wren"},  32'(fb_wren),    32'd0);
    check_val({tag, "_addr"},  32'(fb_addr),    32'd0);
    check_val({tag, "_data"},  32'(fb_data),    32'd0);
    check_val({tag, "_full"},  32'(fifo_full),  32'd0);
    check_val({tag, "_busy"},  32'(busy),       32'd0);
    check_val({tag, "_done"},  32'(clear_done), 32'd0);
    check_val({tag, "_drop"},  32'(dropped),    32'd0);
  endtask

  initial begin
    int n, nwr, guard;
    bit done;
    int rd_pct;

    set_idle();
    model_reset();
    rst = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Single plot lands at 28*160+28 on the next cycle
    plot(28, 28, 3);
    set_idle();
    repeat (2) cycle();

    // Range rejection at both edges, then the far corner
    plot(160, 0, 5);
    plot(0, 120, 6);
    plot(159, 119, 7);
    repeat (2) cycle();

    // Overflow: reads hold the port while ten plots arrive
    rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_addr = 15'($urandom_range(0, 19199));
      plot(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)), int'($urandom_range(0, 7)));
    end
    set_idle();
    repeat (10) cycle();

    // Read priority with a pending write
    plot(1, 2, 4);
    plot(3, 4, 5);
    rd_req  = 1'b1;
    rd_addr = 15'd100;
    cycle();
    set_idle();
    repeat (4) cycle();

    // Random traffic in segments with varying read pressure
    for (int seg = 0; seg < 6; seg++) begin
      rd_pct = (seg % 3 == 2) ? 90 : ((seg % 3 == 1) ? 40 : 10);
      for (int i = 0; i < 500; i++) begin
        plotEn  = ($urandom_range(0, 99) < 60);
        x       = 8'($urandom_range(0, 170));
        y       = 7'($urandom_range(0, 127));
        colour  = 3'($urandom_range(0, 7));
        rd_req  = ($urandom_range(0, 99) < rd_pct);
        rd_addr = 15'($urandom_range(0, 19199));
        cycle();
      end
    end
    set_idle();
    repeat (20) cycle();

    // Full clear with read stalls, a mid-clear plot and an ignored restart
    clear_start  = 1'b1;
    clear_colour = 3'd0;
    cycle();
    set_idle();
    n = 0; nwr = 0; done = 1'b0;
    while (!done && n < 30000) begin
      n++;
      rd_req       = (n == 100 || n == 5000 || n == 5001 || n == 12000 || n == 19100);
      rd_addr      = 15'(n);
      plotEn       = (n == 7000);
      x            = 8'd10;
      y            = 7'd10;
      colour       = 3'd6;
      clear_start  = (n == 9000);
      clear_colour = 3'd7;
      cycle();
      if (obs_wren) nwr++;
      if (clear_done) done = 1'b1;
    end
    check_val("clear_cycles", 32'(n), 32'd19205);
    check_val("clear_writes", 32'(nwr), 32'd19200);
    set_idle();
    repeat (5) cycle();

    // Reset in the middle of a clear
    plot(170, 0, 1);
    clear_start  = 1'b1;
    clear_colour = 3'd5;
    cycle();
    set_idle();
    plot(3, 4, 2);
    guard = 0;
    while (m_cnt != 5000 && guard < 10000) begin
      guard++;
      cycle();
    end
    check_val("clear_reach_5000", 32'(m_cnt), 32'd5000);
    rst = 1'b0;
    #2;
    check_reset_outputs("midclr");
    model_reset();
    @(negedge clk);
    check_reset_outputs("midclr_hold");
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (20) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
